// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends read-key command 0x42 over STB/CLK/DIO, shifts in
// four scan bytes LSB-first and publishes a registered 8-bit key vector.
module tm1638_key_reader #(
  parameter int clk_mhz  = 27,
  parameter int sclk_khz = 500,
  parameter int poll_hz  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       key_change,
  output logic       tm_stb,
  output logic       tm_clk,
  output logic       tm_dio_out,
  output logic       tm_dio_oe,
  input  logic       tm_dio_in
);
  localparam int HALF   = clk_mhz * 1000 / (2 * sclk_khz);
  localparam int PERIOD = clk_mhz * 1_000_000 / poll_hz;
  localparam int CW     = $clog2(2 * HALF + 1);
  localparam int PW     = $clog2(PERIOD + 1);
  localparam logic [7:0] CMD = 8'h42;

  typedef enum logic [2:0] {IDLE, SETUP, CMD_S, WAIT_S, READ_S, HOLD_S} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [4:0]     bitc, bit_n, nb;
  logic           ph, ph_n;
  logic [31:0]    sh, sh_n;
  logic [PW-1:0]  pc;
  logic           poll_hit, go, last;
  logic           stb_n, sclk_n, oe_n, dout_n, kv_n, kc_n;
  logic [7:0]     key_n, dec;

  assign poll_hit = (pc == PW'(PERIOD - 1));
  assign go       = (state == IDLE) && (start || poll_hit);
  assign busy     = (state != IDLE);
  assign last     = (cnt == CW'(HALF - 1));
  assign nb       = bitc + 5'd1;

  // key[i] comes from bit 0 (i<4) or bit 4 (i>=4) of scan byte i%4
  always_comb begin
    dec = '0;
    for (int i = 0; i < 8; i++) dec[i] = sh[8 * (i % 4) + 4 * (i / 4)];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= poll_hit ? '0 : pc + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitc       <= '0;
      ph         <= 1'b0;
      sh         <= '0;
      key        <= '0;
      key_valid  <= 1'b0;
      key_change <= 1'b0;
      tm_stb     <= 1'b1;
      tm_clk     <= 1'b1;
      tm_dio_oe  <= 1'b0;
      tm_dio_out <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bitc       <= bit_n;
      ph         <= ph_n;
      sh         <= sh_n;
      key        <= key_n;
      key_valid  <= kv_n;
      key_change <= kc_n;
      tm_stb     <= stb_n;
      tm_clk     <= sclk_n;
      tm_dio_oe  <= oe_n;
      tm_dio_out <= dout_n;
    end
  end

  // Pin values are computed for the next state so they register in step with it
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bitc;
    ph_n    = ph;
    sh_n    = sh;
    key_n   = key;
    kv_n    = 1'b0;
    kc_n    = 1'b0;
    stb_n   = tm_stb;
    sclk_n  = tm_clk;
    oe_n    = tm_dio_oe;
    dout_n  = tm_dio_out;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        stb_n  = 1'b1;
        sclk_n = 1'b1;
        oe_n   = 1'b0;
        dout_n = 1'b1;
        if (go) begin
          state_n = SETUP;
          stb_n   = 1'b0;
          oe_n    = 1'b1;
        end
      end
      SETUP: if (last) begin
        state_n = CMD_S;
        cnt_n   = '0;
        bit_n   = '0;
        ph_n    = 1'b0;
        sclk_n  = 1'b0;
        dout_n  = CMD[0];
      end
      CMD_S: if (last) begin
        cnt_n = '0;
        if (!ph) begin
          ph_n   = 1'b1;
          sclk_n = 1'b1;
        end else if (bitc == 5'd7) begin
          state_n = WAIT_S;
          oe_n    = 1'b0;
          dout_n  = 1'b1;
        end else begin
          bit_n  = nb;
          ph_n   = 1'b0;
          sclk_n = 1'b0;
          dout_n = CMD[nb[2:0]];
        end
      end
      WAIT_S: if (cnt == CW'(2 * HALF - 1)) begin
        state_n = READ_S;
        cnt_n   = '0;
        bit_n   = '0;
        ph_n    = 1'b0;
        sclk_n  = 1'b0;
      end
      READ_S: if (last) begin
        cnt_n = '0;
        if (!ph) begin
          ph_n   = 1'b1;
          sclk_n = 1'b1;
          sh_n   = {tm_dio_in, sh[31:1]};
        end else if (bitc == 5'd31) begin
          state_n = HOLD_S;
          stb_n   = 1'b1;
        end else begin
          bit_n  = nb;
          ph_n   = 1'b0;
          sclk_n = 1'b0;
        end
      end
      HOLD_S: if (last) begin
        state_n = IDLE;
        key_n   = dec;
        kv_n    = 1'b1;
        kc_n    = (dec != key);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tm1638_key_reader.sv
// Scoreboard bench: a TM1638 bus model serves scan bytes, a frame model predicts
// key_valid timing, and a monitor checks every output against both.
module tb_tm1638_key_reader;
  localparam int CLK_MHZ  = 3;
  localparam int SCLK_KHZ = 500;
  localparam int POLL_HZ  = 5000;
  localparam int HALF     = CLK_MHZ * 1000 / (2 * SCLK_KHZ);
  localparam int PERIOD   = CLK_MHZ * 1_000_000 / POLL_HZ;
  localparam int FLEN     = 84 * HALF;
  localparam logic [7:0] RDCMD = 8'h42;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, key_valid, key_change, tm_stb, tm_clk, tm_dio_out, tm_dio_oe, tm_dio_in;
  logic [7:0] key;
  logic bus_dio = 1'b1, rnd_dio = 1'b0, pollwin = 1'b0;

  int errors = 0, checks = 0, cyc = 0, fend = 0, pc_m = 0;
  int tq[$];
  logic [7:0] kq[$];
  logic [31:0] dq[$];

  assign tm_dio_in = rst ? bus_dio : rnd_dio;

  tm1638_key_reader #(.clk_mhz(CLK_MHZ), .sclk_khz(SCLK_KHZ), .poll_hz(POLL_HZ)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .key(key), .key_valid(key_valid),
    .key_change(key_change), .tm_stb(tm_stb), .tm_clk(tm_clk), .tm_dio_out(tm_dio_out),
    .tm_dio_oe(tm_dio_oe), .tm_dio_in(tm_dio_in));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_key(input logic [31:0] w);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) k[i] = w[8 * (i % 4) + 4 * (i / 4)];
    return k;
  endfunction

  // Frame model: which edges start a frame and when key_valid is due
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      pc_m = 0; fend = 0; tq.delete(); kq.delete();
    end else begin
      if (cyc > fend && (start || pc_m == PERIOD - 1)) begin
        fend = cyc + FLEN;
        tq.push_back(fend);
      end
      pc_m = (pc_m == PERIOD - 1) ? 0 : pc_m + 1;
    end
  end

  // TM1638 bus model: checks the command, serves scan bytes on tm_clk falls
  logic prev_stb = 1'b1, prev_clk = 1'b1;
  int rises = 0, falls = 0, wcnt = 0;
  logic [31:0] rd = '0;
  always @(negedge clk) begin
    if (!rst) begin
      rises = 0; falls = 0; wcnt = 0; bus_dio = 1'b1; prev_stb = 1'b1; prev_clk = 1'b1;
    end else begin
      if (tm_stb != prev_stb) begin
        chk("stb_edge_clk_high", {31'd0, tm_clk & prev_clk}, 1);
        if (!tm_stb) begin
          rd = (dq.size() > 0) ? dq.pop_front() : $urandom;
          kq.push_back(ref_key(rd));
          rises = 0; falls = 0; wcnt = 0;
        end else begin
          chk("frame_rises", rises, 40);
          chk("frame_falls", falls, 40);
          bus_dio = 1'b1;
        end
      end
      if (!tm_stb) begin
        if (tm_clk && !prev_clk) begin
          if (rises < 8) begin
            chk("cmd_bit", {31'd0, tm_dio_out}, {31'd0, RDCMD[rises]});
            chk("cmd_oe", {31'd0, tm_dio_oe}, 1);
          end else chk("read_oe", {31'd0, tm_dio_oe}, 0);
          rises++;
        end
        if (!tm_clk && prev_clk) begin
          if (falls == 8) chk("wait_len_ok", {31'd0, wcnt >= 2 * HALF}, 1);
          if (falls >= 8 && falls < 40) bus_dio = rd[falls - 8];
          falls++;
        end
        if (!tm_dio_oe && tm_clk && falls == 8) wcnt++;
      end
      prev_stb = tm_stb;
      prev_clk = tm_clk;
    end
  end

  // Monitor: pops the scoreboard on key_valid
  logic [7:0] prev_key = '0;
  int last_kv = -1;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_stb", {31'd0, tm_stb}, 1);
      chk("rst_tm_clk", {31'd0, tm_clk}, 1);
      chk("rst_oe", {31'd0, tm_dio_oe}, 0);
      chk("rst_dout", {31'd0, tm_dio_out}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_key", {24'd0, key}, 0);
      chk("rst_kv", {31'd0, key_valid}, 0);
      chk("rst_kc", {31'd0, key_change}, 0);
      prev_key = '0;
      last_kv = -1;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, cyc < fend});
      if (key_valid) begin
        chk("kv_expected", {31'd0, tq.size() > 0}, 1);
        if (tq.size() > 0) chk("kv_cycle", cyc, tq.pop_front());
        if (kq.size() > 0) begin
          logic [7:0] ek;
          ek = kq.pop_front();
          chk("key", {24'd0, key}, {24'd0, ek});
          chk("key_change", {31'd0, key_change}, {31'd0, ek != prev_key});
          prev_key = ek;
        end
        if (pollwin && last_kv >= 0) chk("poll_interval", cyc - last_kv, PERIOD);
        last_kv = cyc;
      end else begin
        chk("kc_without_kv", {31'd0, key_change}, 0);
        chk("key_hold", {24'd0, key}, {24'd0, prev_key});
        if (tq.size() > 0 && tq[0] < cyc) begin
          chk("kv_missing", {31'd0, key_valid}, 1);
          void'(tq.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2 * FLEN) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    dq.push_back(32'h0010_0001);
    dq.push_back(32'h0010_0001);
    dq.push_back(32'hEEEE_EEEE);
    dq.push_back(32'h1111_1111);
    // reset held with random inputs: no frame may start
    repeat (12) begin
      start = 1'($urandom % 2);
      rnd_dio = 1'($urandom % 2);
      step();
    end
    start = 1'b0;
    rst = 1'b1;
    step();
    pulse_start();
    wait_idle();
    pulse_start();
    repeat (100) step();
    pulse_start();
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      step();
      pulse_start();
      wait_idle();
    end
    repeat (6000) begin
      start = ($urandom % 200 == 0);
      step();
    end
    start = 1'b0;
    wait_idle();
    step();
    pulse_start();
    repeat (120) step();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    pollwin = 1'b1;
    repeat (4 * PERIOD + 50) step();
    pollwin = 1'b0;
    wait_idle();
    repeat (5) step();
    chk("pending_frames", tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
